// File: rtl/ariane_soc_pkg.sv
// SoC-wide constants for the AES key fetch path: key count, ROM2 key base and fetch FSM states.
package ariane_soc;

  localparam int unsigned NumAESKeys  = 6;
  localparam logic [31:0] Rom2KeyBase = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone,
    StErr
  } key_fetch_state_e;

endpackage

// File: rtl/key_word_cnt.sv
// Key word counter: counts 0..Max-1 while enabled, wraps to 0, flags the terminal count.
module key_word_cnt #(
  parameter int unsigned Max   = 6,
  parameter int unsigned Width = (Max > 1) ? $clog2(Max) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  assign tc_o  = (cnt_q == Width'(Max - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_key_fetch.sv
// Fetches one AES key (KEY_WORDS x 32 bit) from ROM2 for a peripheral key-table location.
// Optional AES_KEY_FETCH_SCRUB_EN clears key_o the cycle after the key_valid_o pulse.
module aes_key_fetch
  import ariane_soc::*;
#(
  parameter int unsigned KEY_WORDS = 6,
  parameter int unsigned NUM_KEYS  = ariane_soc::NumAESKeys
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic [31:0]             pkey_loc_i,
  output logic                    busy_o,
  output logic                    rom_req_o,
  output logic [31:0]             rom_addr_o,
  input  logic [31:0]             rom_rdata_i,
  output logic [KEY_WORDS*32-1:0] key_o,
  output logic                    key_valid_o,
  output logic                    err_o
);

  localparam int unsigned CntW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  key_fetch_state_e state_d, state_q;

  logic [CntW-1:0]                cnt;
  logic                           cnt_tc;
  logic                           cnt_clr;
  logic                           cnt_en;
  logic                           in_range;
  logic                           accept;
  logic                           reject;
  logic [31:0]                    loc_q;
  logic                           wr_en_q;
  logic [CntW-1:0]                wr_idx_q;
  logic [KEY_WORDS-1:0][31:0]     key_q;

  key_word_cnt #(
    .Max   (KEY_WORDS),
    .Width (CntW)
  ) u_key_word_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  // Range check gates the capture, so the address multiply never sees an out-of-range location.
  assign in_range = (pkey_loc_i < 32'(NUM_KEYS));
  assign accept   = (state_q == StIdle) && req_i && in_range;
  assign reject   = (state_q == StIdle) && req_i && !in_range;

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StFetch;
          cnt_clr = 1'b1;
        end else if (reject) begin
          state_d = StErr;
        end
      end
      StFetch: begin
        cnt_en = 1'b1;
        if (cnt_tc) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ROM data returns one cycle after issue; wr_idx_q remembers which word it belongs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loc_q    <= '0;
      wr_en_q  <= 1'b0;
      wr_idx_q <= '0;
      key_q    <= '0;
    end else begin
      wr_en_q  <= (state_q == StFetch);
      wr_idx_q <= cnt;
      if (accept) begin
        loc_q <= pkey_loc_i;
        key_q <= '0;
      end
      if (reject) begin
        key_q <= '0;
      end
      if (wr_en_q) begin
        key_q[wr_idx_q] <= rom_rdata_i;
      end
`ifdef AES_KEY_FETCH_SCRUB_EN
      if (state_q == StDone) begin
        key_q <= '0;
      end
`endif
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign rom_req_o   = (state_q == StFetch);
  assign rom_addr_o  = rom_req_o ? (Rom2KeyBase + loc_q * 32'(KEY_WORDS) + 32'(cnt)) : 32'h0;
  assign key_o       = key_q;
  assign key_valid_o = (state_q == StDone);
  assign err_o       = (state_q == StErr);

endmodule

// File: tb/tb_aes_key_fetch.sv
// Directed self-checking bench for aes_key_fetch; ROM2 model returns 32'hA000_0000 + address.
module tb_aes_key_fetch;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic [31:0]  pkey_loc;
  logic         busy;
  logic         rom_req;
  logic [31:0]  rom_addr;
  logic [31:0]  rom_rdata;
  logic [191:0] key;
  logic         key_valid;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_romreq = 0;
  int snap_v, snap_r;

  aes_key_fetch dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .pkey_loc_i  (pkey_loc),
    .busy_o      (busy),
    .rom_req_o   (rom_req),
    .rom_addr_o  (rom_addr),
    .rom_rdata_i (rom_rdata),
    .key_o       (key),
    .key_valid_o (key_valid),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM: garbage when not requested so gaps or misaligned captures show up.
  always @(posedge clk) rom_rdata <= rom_req ? (32'hA000_0000 + rom_addr) : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (key_valid) n_valid++;
    if (err)       n_err++;
    if (rom_req)   n_romreq++;
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] exp_key(input int unsigned base);
    logic [191:0] k;
    for (int i = 0; i < 6; i++) k[i*32 +: 32] = 32'hA000_0000 + base + i;
    return k;
  endfunction

  initial begin
    rst_n    = 1'b0;
    req      = 1'b0;
    pkey_loc = 32'h0;
    #1;
    check("reset_outputs", {busy, rom_req, rom_addr, key_valid, err}, '0);
    check("reset_key", key, '0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Normal fetch, location 2: addresses 12..17, key_valid at T+8.
    req = 1'b1; pkey_loc = 32'd2;
    tick();
    req = 1'b0; pkey_loc = 32'd4;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("loc2_req%0d", i), rom_req, 1'b1);
      check($sformatf("loc2_addr%0d", i), rom_addr, 32'd12 + i);
      tick();
    end
    check("loc2_drain_noreq", {rom_req, rom_addr, key_valid}, '0);
    tick();
    check("loc2_valid_t8", key_valid, 1'b1);
    check("loc2_word0", key[31:0], 32'hA000_000C);
    check("loc2_word5", key[191:160], 32'hA000_0011);
    check("loc2_key", key, exp_key(12));
    tick();
    check("loc2_valid_pulse", {key_valid, busy}, 2'b00);
`ifdef AES_KEY_FETCH_SCRUB_EN
    check("loc2_after", key, '0);
`else
    check("loc2_after", key, exp_key(12));
`endif

    // Invalid location: err pulse at T+1, no ROM read, key zeroed.
    snap_r = n_romreq;
    req = 1'b1; pkey_loc = 32'hffff;
    tick();
    req = 1'b0;
    check("err_pulse", {err, busy}, 2'b11);
    check("err_key_zero", key, '0);
    check("err_no_romreq", rom_req, 1'b0);
    tick();
    check("err_one_cycle", {err, busy}, 2'b00);
    tick();
    check("err_romreq_count", n_romreq - snap_r, 0);

    // Boundary: location NUM_KEYS-1 accepted, NUM_KEYS rejected.
    req = 1'b1; pkey_loc = 32'd6;
    tick();
    req = 1'b0;
    check("loc6_err", {err, rom_req}, 2'b10);
    tick();

    // Request while busy is dropped.
    snap_v = n_valid;
    req = 1'b1; pkey_loc = 32'd0;
    tick();
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("busy_addr%0d", i), rom_addr, 32'(i));
      if (i == 2) begin
        req = 1'b1; pkey_loc = 32'd5;
      end else begin
        req = 1'b0;
      end
      tick();
    end
    tick();
    check("busy_valid", key_valid, 1'b1);
    check("busy_key", key, exp_key(0));
    for (int i = 0; i < 6; i++) tick();
    check("busy_one_pulse", n_valid - snap_v, 1);
    check("busy_idle", {busy, rom_req}, 2'b00);

    // Async reset mid-fetch, location 1.
    req = 1'b1; pkey_loc = 32'd1;
    tick();
    req = 1'b0;
    tick(); tick(); tick();
    check("rst_pre_busy", {busy, rom_req}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {busy, rom_req, rom_addr, key_valid, err}, '0);
    check("rst_mid_key", key, '0);
    tick();
    rst_n = 1'b1;
    snap_v = n_valid;
    for (int i = 0; i < 20; i++) tick();
    check("rst_no_valid", n_valid - snap_v, 0);
    check("rst_key_still_zero", key, '0);

    // Back-to-back: second request raised in DONE, accepted in the following IDLE.
    req = 1'b1; pkey_loc = 32'd0;
    tick();
    req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("b2b_done", key_valid, 1'b1);
    req = 1'b1; pkey_loc = 32'd5;
    tick();
    check("b2b_idle_gap", {busy, rom_req}, 2'b00);
    tick();
    req = 1'b0;
    check("b2b_second_addr", {rom_req, rom_addr}, {1'b1, 32'd30});
    for (int i = 0; i < 7; i++) tick();
    check("b2b_valid", key_valid, 1'b1);
    check("b2b_key", key, exp_key(30));
    tick();

    // Location 3: key in valid cycle, then scrubbed or held.
    req = 1'b1; pkey_loc = 32'd3;
    tick();
    req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("loc3_valid", key_valid, 1'b1);
    check("loc3_key", key, exp_key(18));
    tick();
`ifdef AES_KEY_FETCH_SCRUB_EN
    check("loc3_next", key, '0);
`else
    check("loc3_next", key, exp_key(18));
`endif
    for (int i = 0; i < 9; i++) tick();
`ifdef AES_KEY_FETCH_SCRUB_EN
    check("loc3_hold10", key, '0);
`else
    check("loc3_hold10", key, exp_key(18));
`endif
    check("final_err_count", n_err, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
